nixie_display_arbiter: RTL and testbench
========================================

NIXIE_DISPLAY_ARBITER -- requirements
Module: nixie_display_arbiter

Interface
REQ-001 Parameter SCAN_DIV, default 5000: Sys_CLK cycles each digit is lit.
REQ-002 Parameter HOLD_FRAMES, default 64: minimum complete 4-digit frames an owner keeps the display when the other requester is waiting.
REQ-003 Sys_CLK  in  1  single system clock; all state on rising edge.
REQ-004 Sys_RST_N  in  1  asynchronous, active-low reset.
REQ-005 Req  in  2  Req[0] = requester A and Req[1] = requester B want the display; level, held while wanted.
REQ-006 Data_A  in  14  binary value of A, 0..16383.
REQ-007 Data_B  in  14  binary value of B, 0..16383.
REQ-008 Gnt  out  2  one-hot current owner (01 = A, 10 = B); 00 = none.
REQ-009 Busy  out  1  binary-to-BCD conversion in progress.
REQ-010 COM  out  4  active-low digit select: 1110 = units, 1101 = tens, 1011 = hundreds, 0111 = thousands.
REQ-011 SEG  out  8  segments a..g,dp, MSB = a, active-high.

Function
REQ-012 The FSM SHALL have states IDLE, CONV and SHOW.
REQ-013 IDLE behaviour SHALL be: Gnt = 00, Busy = 0, COM = 1111, SEG = 00000000, scan divider and digit index held at 0.
REQ-014 Arbitration from IDLE SHALL be: when Req != 00, register Gnt for the winner and capture its data on the same edge, then enter CONV.
   - Both requesting: the winner is the requester not served last.
   - The last-served pointer resets to B, so A wins the first tie.
REQ-015 Values above 9999 SHALL be clamped to 9999 at capture.
REQ-016 CONV SHALL perform shift-add-3 (double-dabble) conversion, one bit per cycle.
   - 14 cycles, then the result is loaded into the 4-digit display register on the next edge.
   - Busy is high for exactly those 14 cycles.
   - Then go to SHOW.
REQ-017 Digit scanning SHALL run in SHOW, and in CONV whenever the display register holds valid digits.
   - The divider counts 0..SCAN_DIV-1; on wrap, the digit index advances units, tens, hundreds, thousands, units.
   - COM and SEG change on the same edge.
REQ-018 SEG encodings SHALL be:
   - 0 = 11111100, 1 = 01100000, 2 = 11011010, 3 = 11110010, 4 = 01100110
   - 5 = 10110110, 6 = 10111110, 7 = 11100000, 8 = 11111110, 9 = 11110110
   - dp is always 0.
REQ-019 Leading-zero blanking: digits above the most significant nonzero digit SHALL output SEG = 00000000 while COM still selects them; the units digit SHALL always be shown, so value 0 shows "0".
REQ-020 A frame SHALL end when the digit index wraps from thousands to units.
   - The frame counter counts frames since the grant and saturates at HOLD_FRAMES.
REQ-021 At each frame end in SHOW, with the owner still requesting and the other not waiting (or the hold not yet expired), the owner's data SHALL be recaptured and CONV re-entered; the old digits stay displayed until the new load.
REQ-022 At a frame end with frame counter = HOLD_FRAMES and the other requester active, Gnt SHALL switch to the other requester.
   - Its data is captured, the frame counter clears, and CONV is entered.
REQ-023 When the owner drops Req in SHOW or CONV, on the next edge:
   - other requester active: grant it immediately (capture, CONV);
   - otherwise: go to IDLE and invalidate the display register.
   - Simultaneous owner drop and other assert SHALL grant the other.
REQ-024 Gnt SHALL never be 11; Gnt SHALL change only on the arbitration edges defined above.

Reset
REQ-025 On Sys_RST_N low, without waiting for a clock edge, the block SHALL force:
   - state IDLE, Gnt = 00, Busy = 0, COM = 1111, SEG = 00000000;
   - divider, digit index and frame counter 0;
   - display invalid, last-served = B.
   - This applies in any state, including mid-CONV.
REQ-026 After Sys_RST_N deasserts, the first arbitration SHALL occur on the first rising edge that samples Req != 00.

Verification (SCAN_DIV=4, HOLD_FRAMES=2)
REQ-027 Reset with Req=00 -> Gnt=00, Busy=0, COM=1111, SEG=00000000, unchanged for 100 cycles.
REQ-028 Req=01, Data_A=1234 -> Gnt=01 on the next edge; Busy high 14 cycles; then the following scan sequence, repeating:
   - COM=1110 SEG=01100110 for 4 cycles;
   - 1101 / 11110010;
   - 1011 / 11011010;
   - 0111 / 01100000.
REQ-029 Data_A=7 -> units SEG=11100000; tens, hundreds and thousands slots SEG=00000000 with COM still 1101/1011/0111; Data_A=0 -> units 11111100.
REQ-030 Req=11 from IDLE after reset -> Gnt=01; after 2 frames Gnt=10 with Data_B shown; after 2 further frames Gnt=01.
REQ-031 Data_A=12000 -> displays 9999 (11110110 on all four digits).
REQ-032 Sys_RST_N pulsed low at the 7th CONV cycle -> immediate return to the REQ-025 values; on release with Req=01, a fresh 14-cycle conversion occurs.

Source files
------------

// File: rtl/nixie_display_arbiter.sv
// Purpose : two-requester arbiter for a 4-digit multiplexed seven-segment/nixie display, with
//           clamp to 9999, serial double-dabble binary-to-BCD conversion and leading-zero blanking.
// Latency : Gnt one edge after Req is sampled; Busy high 14 cycles; digits loaded on the 14th CONV edge.
// Backpressure: none; requesters hold Req while they want the display and the owner keeps it for
//           at least HOLD_FRAMES complete frames while the other requester waits.
//
// Ports:
//   Sys_CLK    - system clock, all state on the rising edge
//   Sys_RST_N  - asynchronous active-low reset
//   Req[1:0]   - level requests, bit 0 = requester A, bit 1 = requester B
//   Data_A/B   - 14-bit binary values of each requester
//   Gnt[1:0]   - one-hot current owner (01 = A, 10 = B, 00 = none)
//   Busy       - binary-to-BCD conversion in progress
//   COM[3:0]   - active-low digit select (1110 units .. 0111 thousands)
//   SEG[7:0]   - active-high segments a..g,dp with a in the MSB

module nixie_display_arbiter #(
    parameter int SCAN_DIV    = 5000,
    parameter int HOLD_FRAMES = 64
) (
    input  logic        Sys_CLK,
    input  logic        Sys_RST_N,
    input  logic [1:0]  Req,
    input  logic [13:0] Data_A,
    input  logic [13:0] Data_B,
    output logic [1:0]  Gnt,
    output logic        Busy,
    output logic [3:0]  COM,
    output logic [7:0]  SEG
);

    localparam int DIV_W = (SCAN_DIV > 1) ? $clog2(SCAN_DIV) : 1;
    localparam int FRM_W = (HOLD_FRAMES > 0) ? $clog2(HOLD_FRAMES + 1) : 1;

    localparam logic [DIV_W-1:0] DIV_LAST  = DIV_W'(SCAN_DIV - 1);
    localparam logic [FRM_W-1:0] FRM_MAX   = FRM_W'(HOLD_FRAMES);
    localparam logic [13:0]      VAL_MAX   = 14'd9999;
    localparam logic [3:0]       LAST_STEP = 4'd13;

    typedef enum logic [1:0] {
        ST_IDLE = 2'd0,
        ST_CONV = 2'd1,
        ST_SHOW = 2'd2
    } state_t;

    // ------------------------------------------------------------------
    // State
    // ------------------------------------------------------------------
    state_t            state_q,     state_d;
    logic [1:0]        gnt_q,       gnt_d;
    logic              last_b_q,    last_b_d;     // 1: B was served last
    logic [13:0]       bin_q,       bin_d;        // binary shift register
    logic [15:0]       bcd_q,       bcd_d;        // BCD accumulator
    logic [3:0]        bit_cnt_q,   bit_cnt_d;
    logic [15:0]       disp_q,      disp_d;       // displayed digits, units in [3:0]
    logic              disp_vld_q,  disp_vld_d;
    logic [DIV_W-1:0]  div_q,       div_d;
    logic [1:0]        digit_q,     digit_d;      // 0 = units .. 3 = thousands
    logic [FRM_W-1:0]  frame_q,     frame_d;

    // ------------------------------------------------------------------
    // Helpers
    // ------------------------------------------------------------------
    function automatic logic [13:0] clamp_val(input logic [13:0] v);
        return (v > VAL_MAX) ? VAL_MAX : v;
    endfunction

    // One double-dabble step: add 3 to any BCD nibble >= 5, then shift
    // {bcd, bin} left by one. Returns {bcd_next[15:0], bin_next[13:0]}.
    function automatic logic [29:0] dd_step(input logic [15:0] bcd, input logic [13:0] bin);
        logic [15:0] adj;
        adj = bcd;
        for (int i = 0; i < 4; i++) begin
            if (adj[i*4 +: 4] >= 4'd5) begin
                adj[i*4 +: 4] = adj[i*4 +: 4] + 4'd3;
            end
        end
        return {adj[14:0], bin, 1'b0};
    endfunction

    function automatic logic [7:0] seg_enc(input logic [3:0] d);
        logic [7:0] s;
        case (d)
            4'd0:    s = 8'b11111100;
            4'd1:    s = 8'b01100000;
            4'd2:    s = 8'b11011010;
            4'd3:    s = 8'b11110010;
            4'd4:    s = 8'b01100110;
            4'd5:    s = 8'b10110110;
            4'd6:    s = 8'b10111110;
            4'd7:    s = 8'b11100000;
            4'd8:    s = 8'b11111110;
            4'd9:    s = 8'b11110110;
            default: s = 8'b00000000;
        endcase
        return s;
    endfunction

    // ------------------------------------------------------------------
    // Scan timing
    // ------------------------------------------------------------------
    // Scanning runs whenever the display register is valid: always in
    // SHOW, and in CONV during a recapture or handover.
    logic             scan_on;
    logic             div_wrap;
    logic             frame_end;
    logic [FRM_W-1:0] frame_inc;
    logic             owner_req;
    logic             other_req;
    logic [29:0]      dd_next;

    assign scan_on   = disp_vld_q;
    assign div_wrap  = scan_on && (div_q == DIV_LAST);
    assign frame_end = div_wrap && (digit_q == 2'd3);
    assign frame_inc = (frame_q == FRM_MAX) ? frame_q : frame_q + 1'b1;
    assign owner_req = |(Req & gnt_q);
    assign other_req = |(Req & ~gnt_q);
    assign dd_next   = dd_step(bcd_q, bin_q);

    // ------------------------------------------------------------------
    // Next-state logic
    // ------------------------------------------------------------------
    logic start_conv;   // capture a value and (re)start conversion
    logic new_owner;    // the capture belongs to a fresh grant
    logic grant_b;      // captured requester is B

    always_comb begin
        state_d    = state_q;
        gnt_d      = gnt_q;
        last_b_d   = last_b_q;
        bin_d      = bin_q;
        bcd_d      = bcd_q;
        bit_cnt_d  = bit_cnt_q;
        disp_d     = disp_q;
        disp_vld_d = disp_vld_q;
        div_d      = div_q;
        digit_d    = digit_q;
        frame_d    = frame_q;
        start_conv = 1'b0;
        new_owner  = 1'b0;
        grant_b    = 1'b0;

        if (scan_on) begin
            div_d = div_wrap ? '0 : div_q + 1'b1;
            if (div_wrap) begin
                digit_d = digit_q + 2'd1;
            end
            if (frame_end) begin
                frame_d = frame_inc;
            end
        end

        case (state_q)
            ST_IDLE: begin
                div_d   = '0;
                digit_d = '0;
                frame_d = '0;
                if (Req != 2'b00) begin
                    start_conv = 1'b1;
                    new_owner  = 1'b1;
                    // On a tie the requester not served last wins.
                    grant_b    = Req[1] && (!Req[0] || !last_b_q);
                end
            end

            ST_CONV, ST_SHOW: begin
                if (!owner_req) begin
                    if (other_req) begin
                        start_conv = 1'b1;
                        new_owner  = 1'b1;
                        grant_b    = gnt_q[0];
                    end else begin
                        state_d    = ST_IDLE;
                        gnt_d      = 2'b00;
                        disp_vld_d = 1'b0;
                        div_d      = '0;
                        digit_d    = '0;
                        frame_d    = '0;
                    end
                end else if (state_q == ST_CONV) begin
                    bcd_d     = dd_next[29:14];
                    bin_d     = dd_next[13:0];
                    bit_cnt_d = bit_cnt_q + 4'd1;
                    if (bit_cnt_q == LAST_STEP) begin
                        disp_d     = dd_next[29:14];
                        disp_vld_d = 1'b1;
                        state_d    = ST_SHOW;
                    end
                end else if (frame_end) begin
                    if ((frame_inc == FRM_MAX) && other_req) begin
                        start_conv = 1'b1;
                        new_owner  = 1'b1;
                        grant_b    = gnt_q[0];
                    end else begin
                        // Refresh the owner's value; old digits stay lit
                        // until the new conversion loads.
                        start_conv = 1'b1;
                        grant_b    = gnt_q[1];
                    end
                end
            end

            default: begin
                state_d = ST_IDLE;
                gnt_d   = 2'b00;
            end
        endcase

        if (start_conv) begin
            state_d   = ST_CONV;
            gnt_d     = grant_b ? 2'b10 : 2'b01;
            last_b_d  = grant_b;
            bin_d     = clamp_val(grant_b ? Data_B : Data_A);
            bcd_d     = '0;
            bit_cnt_d = '0;
            if (new_owner) begin
                frame_d = '0;
            end
        end
    end

    // ------------------------------------------------------------------
    // Registers
    // ------------------------------------------------------------------
    always_ff @(posedge Sys_CLK or negedge Sys_RST_N) begin
        if (!Sys_RST_N) begin
            state_q    <= ST_IDLE;
            gnt_q      <= 2'b00;
            last_b_q   <= 1'b1;
            bin_q      <= '0;
            bcd_q      <= '0;
            bit_cnt_q  <= '0;
            disp_q     <= '0;
            disp_vld_q <= 1'b0;
            div_q      <= '0;
            digit_q    <= '0;
            frame_q    <= '0;
        end else begin
            state_q    <= state_d;
            gnt_q      <= gnt_d;
            last_b_q   <= last_b_d;
            bin_q      <= bin_d;
            bcd_q      <= bcd_d;
            bit_cnt_q  <= bit_cnt_d;
            disp_q     <= disp_d;
            disp_vld_q <= disp_vld_d;
            div_q      <= div_d;
            digit_q    <= digit_d;
            frame_q    <= frame_d;
        end
    end

    // ------------------------------------------------------------------
    // Outputs (decoded from registers only, so reset clears them at once)
    // ------------------------------------------------------------------
    logic [3:0] cur_digit;
    logic       blank;

    assign cur_digit = disp_q[digit_q*4 +: 4];

    // Digits above the most significant nonzero digit are dark; units never.
    always_comb begin
        blank = 1'b0;
        case (digit_q)
            2'd1:    blank = (disp_q[15:4]  == 12'd0);
            2'd2:    blank = (disp_q[15:8]  == 8'd0);
            2'd3:    blank = (disp_q[15:12] == 4'd0);
            default: blank = 1'b0;
        endcase
    end

    assign Gnt  = gnt_q;
    assign Busy = (state_q == ST_CONV);
    assign COM  = scan_on ? ~(4'b0001 << digit_q) : 4'b1111;
    assign SEG  = (scan_on && !blank) ? seg_enc(cur_digit) : 8'b00000000;

endmodule

// File: tb/tb_nixie_display_arbiter.sv
// Directed bench for nixie_display_arbiter with SCAN_DIV=4, HOLD_FRAMES=2.
// Expected segment patterns and timing are hand-derived constants.

module tb_nixie_display_arbiter;

    logic        Sys_CLK   = 1'b0;
    logic        Sys_RST_N = 1'b0;
    logic [1:0]  Req       = 2'b00;
    logic [13:0] Data_A    = 14'd0;
    logic [13:0] Data_B    = 14'd0;
    logic [1:0]  Gnt;
    logic        Busy;
    logic [3:0]  COM;
    logic [7:0]  SEG;

    int checks   = 0;
    int failures = 0;

    localparam logic [7:0] S0 = 8'b11111100;
    localparam logic [7:0] S1 = 8'b01100000;
    localparam logic [7:0] S2 = 8'b11011010;
    localparam logic [7:0] S3 = 8'b11110010;
    localparam logic [7:0] S4 = 8'b01100110;
    localparam logic [7:0] S5 = 8'b10110110;
    localparam logic [7:0] S6 = 8'b10111110;
    localparam logic [7:0] S7 = 8'b11100000;
    localparam logic [7:0] S9 = 8'b11110110;
    localparam logic [7:0] BL = 8'b00000000;

    nixie_display_arbiter #(
        .SCAN_DIV    (4),
        .HOLD_FRAMES (2)
    ) dut (
        .Sys_CLK   (Sys_CLK),
        .Sys_RST_N (Sys_RST_N),
        .Req       (Req),
        .Data_A    (Data_A),
        .Data_B    (Data_B),
        .Gnt       (Gnt),
        .Busy      (Busy),
        .COM       (COM),
        .SEG       (SEG)
    );

    always #5 Sys_CLK = ~Sys_CLK;

    task automatic tick;
        @(posedge Sys_CLK);
        #1;
    endtask

    task automatic chk(input string tag, input logic [15:0] obs, input logic [15:0] exp);
        checks++;
        assert (obs === exp) else begin
            failures++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    task automatic chk_idle(input string tag);
        chk({tag, "_gnt"},  16'(Gnt),  16'h0);
        chk({tag, "_busy"}, 16'(Busy), 16'h0);
        chk({tag, "_com"},  16'(COM),  16'hF);
        chk({tag, "_seg"},  16'(SEG),  16'h0);
    endtask

    // Called on the first sample after a grant edge: Busy must stay high for 14 samples.
    task automatic wait_conv(input string tag);
        int n;
        n = 0;
        while (Busy === 1'b1 && n < 100) begin
            tick;
            n++;
        end
        chk(tag, 16'(n), 16'd14);
    endtask

    // Align to the start of a units slot (bounded).
    task automatic sync_units(input string tag);
        int n;
        n = 0;
        while (COM !== 4'b0111 && n < 40) begin
            tick;
            n++;
        end
        while (COM !== 4'b1110 && n < 40) begin
            tick;
            n++;
        end
        chk(tag, 16'(n < 40), 16'd1);
    endtask

    // One full frame from the start of the units slot: 4 digits x 4 cycles.
    task automatic check_frame(input string tag, input logic [7:0] s0, input logic [7:0] s1,
                               input logic [7:0] s2, input logic [7:0] s3);
        logic [7:0] segs [4];
        logic [3:0] coms [4];
        segs[0] = s0; segs[1] = s1; segs[2] = s2; segs[3] = s3;
        coms[0] = 4'b1110; coms[1] = 4'b1101; coms[2] = 4'b1011; coms[3] = 4'b0111;
        for (int d = 0; d < 4; d++) begin
            for (int c = 0; c < 4; c++) begin
                chk({tag, "_com"}, 16'(COM), 16'(coms[d]));
                chk({tag, "_seg"}, 16'(SEG), 16'(segs[d]));
                tick;
            end
        end
    endtask

    // Release the display, then request it again with a new A value.
    task automatic regrant_a(input string tag, input logic [13:0] val);
        Req = 2'b00;
        tick;
        chk_idle({tag, "_idle"});
        Data_A = val;
        Req    = 2'b01;
        tick;
        chk({tag, "_gnt"}, 16'(Gnt), 16'h1);
        wait_conv({tag, "_conv"});
    endtask

    initial begin
        // Reset and quiet idle
        Sys_RST_N = 1'b0;
        Req       = 2'b00;
        repeat (3) tick;
        chk_idle("rst");
        Sys_RST_N = 1'b1;
        for (int i = 0; i < 100; i++) begin
            tick;
            chk_idle("idle_hold");
        end

        // Single requester, value 1234
        Data_A = 14'd1234;
        Req    = 2'b01;
        chk("pre_grant", 16'(Gnt), 16'h0);
        tick;
        chk("grant_a", 16'(Gnt), 16'h1);
        chk("busy_on", 16'(Busy), 16'h1);
        wait_conv("busy_1234");
        check_frame("f1234a", S4, S3, S2, S1);
        check_frame("f1234b", S4, S3, S2, S1);
        chk("gnt_kept", 16'(Gnt), 16'h1);

        // Leading-zero blanking, zero, clamp
        regrant_a("v7", 14'd7);
        check_frame("f7", S7, BL, BL, BL);
        regrant_a("v0", 14'd0);
        check_frame("f0", S0, BL, BL, BL);
        regrant_a("v12000", 14'd12000);
        check_frame("f9999", S9, S9, S9, S9);

        // Owner drops while the other asserts on the same edge
        Data_B = 14'd56;
        Req    = 2'b10;
        tick;
        chk("handover_gnt", 16'(Gnt), 16'h2);
        chk("handover_busy", 16'(Busy), 16'h1);
        Req = 2'b00;
        tick;
        chk_idle("drop_idle");

        // Tie from reset: A first, B after two frames, then A again
        Sys_RST_N = 1'b0;
        #1;
        chk_idle("rst_async");
        tick;
        Sys_RST_N = 1'b1;
        Data_A = 14'd1234;
        Data_B = 14'd56;
        Req    = 2'b11;
        tick;
        chk("tie_first", 16'(Gnt), 16'h1);
        wait_conv("tie_conv_a");
        repeat (31) tick;
        chk("tie_hold_a", 16'(Gnt), 16'h1);
        tick;
        chk("tie_switch_b", 16'(Gnt), 16'h2);
        wait_conv("tie_conv_b");
        sync_units("tie_sync_b");
        check_frame("fB", S6, S5, BL, BL);
        chk("tie_switch_a", 16'(Gnt), 16'h1);

        // Reset during the 7th conversion cycle
        Req = 2'b00;
        tick;
        chk_idle("pre_mid");
        Req = 2'b01;
        tick;
        chk("mid_busy", 16'(Busy), 16'h1);
        repeat (6) tick;
        chk("mid_busy7", 16'(Busy), 16'h1);
        Sys_RST_N = 1'b0;
        #1;
        chk_idle("rst_mid");
        tick;
        chk_idle("rst_mid_hold");
        Sys_RST_N = 1'b1;
        chk("post_rst_pre", 16'(Gnt), 16'h0);
        tick;
        chk("post_rst_gnt", 16'(Gnt), 16'h1);
        wait_conv("post_rst_conv");
        check_frame("f1234c", S4, S3, S2, S1);

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

    initial begin
        #100000;
        $display("FAIL watchdog timeout checks=%0d failures=%0d", checks, failures);
        $fatal(1, "watchdog");
    end

endmodule
